// File: rtl/gf283_reduce_seq.sv
// Digit-serial reducer mod f(x) = x^283 + x^12 + x^7 + x^5 + 1, DIGIT upper bits per clock.
// Optional early exit when no bits remain above 282: define GF283_ZERO_SKIP_EN.
module gf283_reduce_seq #(
  parameter int DIGIT = 47
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [564:0] c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [282:0] z,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, FOLD = 2'd1, DONE = 2'd2} state_t;

  localparam logic [564:0] DIGIT_MASK = (565'd1 << DIGIT) - 565'd1;

  state_t       state_r;
  logic [564:0] r_r;
  logic [9:0]   t_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic [282:0] z_r;

  logic [9:0]   bot_s;
  logic [564:0] chunk_s;
  logic [564:0] r_fold_s;
  logic         last_s;
  logic         upper_zero_s;

  // x^283 == x^12 + x^7 + x^5 + 1, so a chunk lands on four shifted copies of itself
  function automatic logic [564:0] fold_poly(input logic [564:0] v);
    return v ^ (v << 5) ^ (v << 7) ^ (v << 12);
  endfunction

  // Fold the chunk r[t : t-DIGIT+1]; all targets fall strictly below the chunk bottom
  always_comb begin
    bot_s        = t_r - 10'(DIGIT - 1);
    chunk_s      = (r_r >> bot_s) & DIGIT_MASK;
    r_fold_s     = (r_r & ~(DIGIT_MASK << bot_s)) ^ (fold_poly(chunk_s) << (bot_s - 10'd283));
    last_s       = (bot_s == 10'd283);
    upper_zero_s = (r_r[564:283] == 282'd0);
  end

  // Control FSM, working register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= 565'd0;
      t_r         <= 10'd564;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      z_r         <= 283'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            r_r        <= c_in;
            t_r        <= 10'd564;
            state_r    <= FOLD;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        FOLD: begin
`ifdef GF283_ZERO_SKIP_EN
          if (upper_zero_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            z_r         <= r_r[282:0];
          end else begin
            r_r <= r_fold_s;
            t_r <= t_r - 10'(DIGIT);
            if (last_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              z_r         <= r_fold_s[282:0];
            end
          end
`else
          r_r <= r_fold_s;
          t_r <= t_r - 10'(DIGIT);
          if (last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            z_r         <= r_fold_s[282:0];
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign z         = z_r;

endmodule
